// File: rtl/paridade_pkg.sv
// Shared types and helpers for the frame parity generator.
//   estado_t  : frame FSM states (IDLE, ACC, HOLD)
//   calc_cw   : width of a counter that can hold 0..MAX_WORDS
//   PAR_EVEN / PAR_ODD : parity mode encodings (also the XOR mask applied to acc)
package paridade_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } estado_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int calc_cw(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/paridade_palavra.sv
// Combinational XOR reduction of one data word.
//   data   : WIDTH-bit word
//   parity : XOR of all bits of data (1 when the word has an odd number of ones)
module paridade_palavra #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/gerador_paridade_quadro.sv
// Frame parity generator: accumulates the parity of a frame of WIDTH-bit
// words received on a valid/ready stream and emits one parity bit per frame,
// even or odd as selected by odd_mode on the frame's first beat.
// A frame closes on in_last or when MAX_WORDS words have been accepted.
//
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : input word handshake
//   in_data, in_last      : word and end-of-frame marker
//   odd_mode              : 0 even / 1 odd parity, sampled on the first beat
//   out_valid/out_ready   : result handshake
//   out_parity            : frame parity bit
//   out_count             : words in the frame
//   out_ovf               : frame closed by MAX_WORDS without in_last
//   in_par, out_err       : only with PARIDADE_CHECK_EN defined; out_err is
//                           the received parity bit XOR the computed one
//
// Optional feature macro: PARIDADE_CHECK_EN
module gerador_paridade_quadro
    import paridade_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CW        = calc_cw(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
`ifdef PARIDADE_CHECK_EN
   ,input  logic             in_par,
    output logic             out_err
`endif
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);

    estado_t        st;
    logic           acc;
    logic [CW-1:0]  cnt;
    logic           odd_r;

    logic           word_par;
    logic           beat;
    logic           first;
    logic           acc_n;
    logic [CW-1:0]  cnt_n;
    logic           odd_n;
    logic           par_n;
    logic           close;

    paridade_palavra #(.WIDTH(WIDTH)) u_palavra (
        .data   (in_data),
        .parity (word_par)
    );

    // Next-state values for the beat being accepted this cycle. On the first
    // beat the accumulator and mode load fresh instead of using old state.
    always_comb begin
        beat  = in_valid && in_ready;
        first = (st == IDLE);
        acc_n = first ? word_par : (acc ^ word_par);
        cnt_n = first ? CW'(1) : ((cnt == MAXC) ? cnt : cnt + CW'(1));
        odd_n = first ? odd_mode : odd_r;
        par_n = acc_n ^ odd_n;
        close = in_last || (cnt_n == MAXC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            odd_r      <= PAR_EVEN;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
`ifdef PARIDADE_CHECK_EN
            out_err    <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE, ACC: begin
                    // in_ready comes up here on the first edge after reset
                    in_ready <= 1'b1;
                    if (beat) begin
                        acc   <= acc_n;
                        cnt   <= cnt_n;
                        odd_r <= odd_n;
                        if (close) begin
                            st         <= HOLD;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            out_parity <= par_n;
                            out_count  <= cnt_n;
                            // in_last on the MAX_WORDS-th word is a normal close
                            out_ovf    <= ~in_last;
`ifdef PARIDADE_CHECK_EN
                            out_err    <= in_par ^ par_n;
`endif
                        end else begin
                            st <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        st         <= IDLE;
                        in_ready   <= 1'b1;
                        out_valid  <= 1'b0;
                        acc        <= 1'b0;
                        cnt        <= '0;
                        out_parity <= 1'b0;
                        out_count  <= '0;
                        out_ovf    <= 1'b0;
`ifdef PARIDADE_CHECK_EN
                        out_err    <= 1'b0;
`endif
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gerador_paridade_quadro.sv
module tb_gerador_paridade_quadro;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             odd_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_ovf;
`ifdef PARIDADE_CHECK_EN
    logic             in_par = 1'b0;
    logic             out_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gerador_paridade_quadro #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .odd_mode   (odd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
`ifdef PARIDADE_CHECK_EN
       ,.in_par     (in_par),
        .out_err    (out_err)
`endif
    );

    // Presents one word starting at a negedge and returns at the negedge after
    // the edge that accepted it. in_ready only moves on posedge, so its value
    // at a negedge is what the next posedge sees.
    task automatic beat(input logic [7:0] d, input logic l, input logic o);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l; odd_mode = o;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("FAIL beat_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'hAA;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if ({out_valid, out_parity, out_count, out_ovf} !== 6'b0) begin bad++;
            $display("FAIL rst_outputs: got %b%b%0d%b want all 0", out_valid, out_parity, out_count, out_ovf); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready: got %b want 0", in_ready); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", in_ready); end
    endtask

    task automatic test_even();
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL even_valid: got %b want 1", out_valid); end
        total++; if (out_parity !== 1'b1) begin bad++; $display("FAIL even_parity: got %b want 1", out_parity); end
        total++; if (out_count !== 3'd3) begin bad++; $display("FAIL even_count: got %0d want 3", out_count); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL even_ovf: got %b want 0", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL even_hold_ready: got %b want 0", in_ready); end
        release_result();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL even_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_odd_latch();
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h03, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1 || out_parity !== 1'b0) begin bad++;
            $display("FAIL odd_parity: valid=%b parity=%b want 1/0", out_valid, out_parity); end
        release_result();
        // single word odd frame: 0x07 has three ones -> acc=1 -> odd gives 0
        beat(8'h07, 1'b1, 1'b1);
        total++; if (out_parity !== 1'b0 || out_count !== 3'd1) begin bad++;
            $display("FAIL odd_single: parity=%b count=%0d want 0/1", out_parity, out_count); end
        release_result();
    endtask

    task automatic test_overflow();
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_count !== 3'd4 || out_ovf !== 1'b1 || out_parity !== 1'b1) begin bad++;
            $display("FAIL ovf_result: valid=%b count=%0d ovf=%b parity=%b want 1/4/1/1", out_valid, out_count, out_ovf, out_parity); end
        // word 5 is offered while the result is pending and must wait
        in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1; odd_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0 || out_count !== 3'd4) begin bad++;
                $display("FAIL ovf_hold: ready=%b count=%0d want 0/4", in_ready, out_count); end
        end
        release_result();
        beat(8'h03, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1 || out_count !== 3'd1 || out_ovf !== 1'b0 || out_parity !== 1'b0) begin bad++;
            $display("FAIL ovf_word5: valid=%b count=%0d ovf=%b parity=%b want 1/1/0/0", out_valid, out_count, out_ovf, out_parity); end
        release_result();
        // in_last on the MAX_WORDS-th word is a normal close
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b0);
        total++; if (out_count !== 3'd4 || out_ovf !== 1'b0 || out_parity !== 1'b1) begin bad++;
            $display("FAIL max_with_last: count=%0d ovf=%b parity=%b want 4/0/1", out_count, out_ovf, out_parity); end
        release_result();
    endtask

    task automatic test_backpressure();
        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL idle_out_ready: valid=%b ready=%b want 0/1", out_valid, in_ready); end
        beat(8'h07, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_count !== 3'd1 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin bad++;
                $display("FAIL stall_stable: valid=%b parity=%b count=%0d ovf=%b ready=%b want 1/1/1/0/0",
                         out_valid, out_parity, out_count, out_ovf, in_ready); end
        end
        release_result();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL stall_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_midframe();
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if ({in_ready, out_valid, out_parity, out_count, out_ovf} !== 7'b0) begin bad++;
            $display("FAIL midrst_outputs: ready=%b valid=%b parity=%b count=%0d ovf=%b want all 0",
                     in_ready, out_valid, out_parity, out_count, out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL midrst_after: valid=%b ready=%b want 0/1", out_valid, in_ready); end
        beat(8'h80, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_count !== 3'd1) begin bad++;
            $display("FAIL midrst_frame: valid=%b parity=%b count=%0d want 1/1/1", out_valid, out_parity, out_count); end
        release_result();
    endtask

`ifdef PARIDADE_CHECK_EN
    task automatic test_check();
        in_par = 1'b0;
        beat(8'h0F, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        total++; if (out_parity !== 1'b1 || out_err !== 1'b1) begin bad++;
            $display("FAIL check_err1: parity=%b err=%b want 1/1", out_parity, out_err); end
        release_result();
        in_par = 1'b1;
        beat(8'h0F, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        total++; if (out_parity !== 1'b1 || out_err !== 1'b0) begin bad++;
            $display("FAIL check_err0: parity=%b err=%b want 1/0", out_parity, out_err); end
        release_result();
    endtask
`endif

    initial begin
        test_reset();
        test_even();
        test_odd_latch();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
`ifdef PARIDADE_CHECK_EN
        test_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
